// File: rtl/csel_pkg.sv
// Shared constants and sizing helpers for the pipelined carry-select adder.
package csel_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_GROUP = 8;

  // Per-stage control bits carried next to the data: valid and group carry.
  localparam int STAGE_CTRL_BITS = 2;

  function automatic int num_stages(input int width, input int group);
    return width / group;
  endfunction

  // One stage word: {valid, carry, b_eff[width], partial_sum/A[width]}.
  function automatic int payload_bits(input int width);
    return 2 * width + STAGE_CTRL_BITS;
  endfunction

endpackage

// File: rtl/csel_block.sv
// One GROUP-bit carry-select block: both ripple sums are formed up front and the
// incoming carry only steers a mux, so the block carry path is a single select.
module csel_block
  import csel_pkg::*;
#(
  parameter int GROUP = DEF_GROUP
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout
);

  logic [GROUP:0]   c0;
  logic [GROUP:0]   c1;
  logic [GROUP-1:0] s0;
  logic [GROUP-1:0] s1;

  // NOTE: every variable in this always_comb is written on every path before it
  // is read, so no latch can be inferred.
  always_comb begin
    c0[0] = 1'b0;
    c1[0] = 1'b1;
    for (int i = 0; i < GROUP; i++) begin
      s0[i]   = a[i] ^ b[i] ^ c0[i];
      c0[i+1] = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
      s1[i]   = a[i] ^ b[i] ^ c1[i];
      c1[i+1] = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
    end
  end

  assign sum  = cin ? s1 : s0;
  assign cout = cin ? c1[GROUP] : c0[GROUP];

endmodule

// File: rtl/pipelined_csel_adder.sv
// WIDTH-bit pipelined carry-select adder/subtractor, one GROUP-bit block resolved
// per stage, valid/ready flow control. Define CSEL_OVF_EN to add the Ovf output.
module pipelined_csel_adder
  import csel_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GROUP = DEF_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             out_valid,
  input  logic             out_ready
`ifdef CSEL_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int N     = num_stages(WIDTH, GROUP);
  localparam int PW    = payload_bits(WIDTH);
  localparam int C_BIT = 2 * WIDTH;
  localparam int V_BIT = 2 * WIDTH + 1;

  if ((GROUP < 1) || ((WIDTH % GROUP) != 0)) begin : g_bad_cfg
    $error("pipelined_csel_adder: WIDTH must be a non-zero multiple of GROUP");
  end

  // Resolved groups overwrite the A bits in place, so the low part of a stage
  // word is the partial sum and the high part is still-unresolved A.
  logic [PW-1:0] stage_q [1:N];
  logic [PW-1:0] stage_d [1:N];
  logic [N:1]    adv;
  logic          take;

`ifdef CSEL_OVF_EN
  logic ovf_d;
  logic ovf_q;
`endif

  // A stage may load when it is empty or the stage after it is moving.
  always_comb begin
    adv[N] = ~stage_q[N][V_BIT] | out_ready;
    for (int k = N - 1; k >= 1; k--) begin
      adv[k] = ~stage_q[k][V_BIT] | adv[k+1];
    end
  end

  assign in_ready = adv[1] & ~rst;
  assign take     = in_valid & in_ready;

  for (genvar g = 0; g < N; g++) begin : g_stage
    localparam logic [WIDTH-1:0] GMASK = WIDTH'({GROUP{1'b1}}) << (g * GROUP);

    logic [PW-1:0]    src;
    logic [GROUP-1:0] blk_sum;
    logic             blk_cout;

    if (g == 0) begin : g_head
      assign src = {take, Cin ^ Sub, B ^ {WIDTH{Sub}}, A};
    end else begin : g_body
      assign src = stage_q[g];
    end

    csel_block #(.GROUP(GROUP)) u_blk (
      .a    (src[g*GROUP +: GROUP]),
      .b    (src[WIDTH + g*GROUP +: GROUP]),
      .cin  (src[C_BIT]),
      .sum  (blk_sum),
      .cout (blk_cout)
    );

    assign stage_d[g+1] = {src[V_BIT], blk_cout, src[2*WIDTH-1:WIDTH],
                           (src[WIDTH-1:0] & ~GMASK) | (WIDTH'(blk_sum) << (g * GROUP))};

`ifdef CSEL_OVF_EN
    if (g == N - 1) begin : g_ovf
      // Carry into the MSB is a ^ b ^ sum at that bit; overflow is it XOR Cout.
      assign ovf_d = src[WIDTH-1] ^ src[2*WIDTH-1] ^ blk_sum[GROUP-1] ^ blk_cout;
    end
`endif
  end

  // NOTE: state is updated with non-blocking assignments so every stage samples
  // its neighbour's pre-edge value; blocking here would collapse the pipeline.
  // NOTE: the stage registers are ordinary flops (not a RAM), so they are all
  // cleared by reset and the outputs read 0 while rst is high.
  always_ff @(posedge clk) begin
    for (int k = 1; k <= N; k++) begin
      if (rst) begin
        stage_q[k] <= '0;
      end else if (adv[k]) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

`ifdef CSEL_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv[N]) begin
      ovf_q <= ovf_d;
    end
  end

  assign Ovf = ovf_q;
`endif

  assign S         = stage_q[N][WIDTH-1:0];
  assign Cout      = stage_q[N][C_BIT];
  assign out_valid = stage_q[N][V_BIT];

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Bench for pipelined_csel_adder: an 8/4 instance driven from a vector table and
// a default 32/8 instance for latency, backpressure and random/reset streams.
module tb_pipelined_csel_adder;

  typedef struct packed {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       cout;
    logic       ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  a8, b8, s8;
  logic        cin8, sub8, iv8, ir8, co8, ov8, or8;
  logic [31:0] a32, b32, s32;
  logic        cin32, sub32, iv32, ir32, co32, ov32, or32;
`ifdef CSEL_OVF_EN
  logic        ovf8, ovf32;
`endif

  exp_t q8[$];
  exp_t q32[$];
  int   checks   = 0;
  int   failures = 0;
  bit   rand_on;

  pipelined_csel_adder #(.WIDTH(8), .GROUP(4)) u_dut8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .Cin(cin8), .Sub(sub8),
    .in_valid(iv8), .in_ready(ir8), .S(s8), .Cout(co8),
    .out_valid(ov8), .out_ready(or8)
`ifdef CSEL_OVF_EN
    , .Ovf(ovf8)
`endif
  );

  pipelined_csel_adder u_dut32 (
    .clk(clk), .rst(rst), .A(a32), .B(b32), .Cin(cin32), .Sub(sub32),
    .in_valid(iv32), .in_ready(ir32), .S(s32), .Cout(co32),
    .out_valid(ov32), .out_ready(or32)
`ifdef CSEL_OVF_EN
    , .Ovf(ovf32)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic; subtraction borrows when Cin=1.
  function automatic exp_t model32(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
    exp_t        e;
    logic [32:0] r;
    longint      sres;
    if (sub) begin
      r    = 33'h1_0000_0000 + {1'b0, a} - {1'b0, b} - 33'(cin);
      sres = longint'($signed(a)) - longint'($signed(b)) - longint'(cin);
    end else begin
      r    = {1'b0, a} + {1'b0, b} + 33'(cin);
      sres = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    end
    e.s    = r[31:0];
    e.cout = r[32];
    e.ovf  = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
    return e;
  endfunction

  // Scoreboards: a transfer is observed at the negedge before the edge that makes it.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q8.delete();
    end else if (ov8 && or8) begin
      check("dut8 output has expectation", q8.size() != 0, 1);
      if (q8.size() != 0) begin
        e = q8.pop_front();
        check("dut8 S", s8, e.s[7:0]);
        check("dut8 Cout", co8, e.cout);
`ifdef CSEL_OVF_EN
        check("dut8 Ovf", ovf8, e.ovf);
`endif
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q32.delete();
    end else if (ov32 && or32) begin
      check("dut32 output has expectation", q32.size() != 0, 1);
      if (q32.size() != 0) begin
        e = q32.pop_front();
        check("dut32 S", s32, e.s);
        check("dut32 Cout", co32, e.cout);
`ifdef CSEL_OVF_EN
        check("dut32 Ovf", ovf32, e.ovf);
`endif
      end
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send8(input vec_t v);
    a8 = v.a; b8 = v.b; cin8 = v.cin; sub8 = v.sub; iv8 = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (ir8) begin
        q8.push_back('{s: {24'h0, v.s}, cout: v.cout, ovf: v.ovf});
        @(posedge clk); #1;
        iv8 = 1'b0;
        return;
      end
    end
    check("dut8 accept within budget", ir8, 1);
    iv8 = 1'b0;
  endtask

  // Leaves in_valid high when not accepted within the budget (ends at a negedge).
  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub, input int budget, output bit acc);
    a32 = a; b32 = b; cin32 = cin; sub32 = sub; iv32 = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (ir32) begin
        q32.push_back(model32(a, b, cin, sub));
        @(posedge clk); #1;
        iv32 = 1'b0;
        acc  = 1'b1;
        return;
      end
    end
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (q8.size() == 0 && q32.size() == 0) break;
    end
    check("dut8 scoreboard drained", q8.size(), 0);
    check("dut32 scoreboard drained", q32.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    bit   acc;
    int   accepted;

    tbl[0]  = '{8'h96, 8'h79, 1'b0, 1'b0, 8'h0F, 1'b1, 1'b0};
    tbl[1]  = '{8'h96, 8'h79, 1'b0, 1'b1, 8'h1D, 1'b1, 1'b1};
    tbl[2]  = '{8'h79, 8'h96, 1'b0, 1'b1, 8'hE3, 1'b0, 1'b1};
    tbl[3]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[4]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[5]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[6]  = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[7]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[8]  = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[9]  = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    tbl[10] = '{8'h3C, 8'h4B, 1'b1, 1'b0, 8'h88, 1'b0, 1'b1};
    tbl[11] = '{8'h50, 8'h20, 1'b1, 1'b1, 8'h2F, 1'b1, 1'b0};

    rst = 1'b1;
    a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b0; or8 = 1'b1;
    a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0; iv32 = 1'b0; or32 = 1'b1;
    rand_on = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset dut8 S", s8, 0);
    check("reset dut8 Cout", co8, 0);
    check("reset dut8 out_valid", ov8, 0);
    check("reset dut8 in_ready", ir8, 0);
    check("reset dut32 S", s32, 0);
    check("reset dut32 Cout", co32, 0);
    check("reset dut32 out_valid", ov32, 0);
    check("reset dut32 in_ready", ir32, 0);
`ifdef CSEL_OVF_EN
    check("reset dut8 Ovf", ovf8, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("dut8 in_ready after reset", ir8, 1);
    check("dut32 in_ready after reset", ir32, 1);

    // 8/4 latency: accepted at edge t, visible after edge t+1.
    a8 = 8'h96; b8 = 8'h79; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1;
    q8.push_back('{s: 32'h0F, cout: 1'b1, ovf: 1'b0});
    @(posedge clk); #1;
    iv8 = 1'b0;
    @(negedge clk);
    check("dut8 out_valid after edge t", ov8, 0);
    @(negedge clk);
    check("dut8 out_valid after edge t+1", ov8, 1);

    // 32/8 carry through every stage, latency 4.
    @(posedge clk); #1;
    a32 = 32'hFFFF_FFFF; b32 = '0; cin32 = 1'b1; sub32 = 1'b0; iv32 = 1'b1;
    @(negedge clk);
    check("dut32 in_ready idle", ir32, 1);
    q32.push_back('{s: 32'h0, cout: 1'b1, ovf: 1'b0});
    @(posedge clk); #1;
    iv32 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("dut32 out_valid low after edge t+%0d", k), ov32, 0);
    end
    @(negedge clk);
    check("dut32 out_valid after edge t+3", ov32, 1);
    @(posedge clk); #1;

    // Table of 8/4 vectors, back to back.
    foreach (tbl[i]) send8(tbl[i]);
    drain(50);
    @(posedge clk); #1;

    // Backpressure: four fill the pipe, the fifth waits for out_ready.
    or32 = 1'b0;
    accepted = 0;
    for (int i = 1; i <= 5; i++) begin
      send32(32'(i), 32'(i), 1'b0, 1'b0, 8, acc);
      if (acc) accepted++;
    end
    check("accepted before stall", accepted, 4);
    check("in_ready low when full", ir32, 0);
    check("out_valid held while stalled", ov32, 1);
    @(posedge clk); #1;
    or32 = 1'b1;
    @(negedge clk);
    check("in_ready with full pipe draining", ir32, 1);
    check("stream valid 1", ov32, 1);
    q32.push_back(model32(32'd5, 32'd5, 1'b0, 1'b0));
    @(posedge clk); #1;
    iv32 = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("stream valid %0d", k), ov32, 1);
    end
    drain(20);
    @(posedge clk); #1;

    // Random stream, random out_ready, one reset pulse mid-stream.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          send32($urandom(), $urandom(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 60, acc);
          if (!acc) begin
            check("random accept within budget", ir32, 1);
            iv32 = 1'b0;
            @(posedge clk); #1;
          end
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          or32 = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        repeat (25) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid reset out_valid", ov32, 0);
        check("mid reset S", s32, 0);
        check("mid reset Cout", co32, 0);
      end
    join
    or32 = 1'b1;
    drain(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
